// File: rtl/div_pkg.sv
// Shared definitions for the iterative radix-2 divider: state encoding,
// counter sizing, special-case constants and two's-complement negation.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_MAX_W = 64;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY,
    DONE = ST_DONE
  } div_state_t;

  // Helpers work on a wide word; callers truncate to their own WIDTH.
  typedef logic [DIV_MAX_W-1:0] div_word_t;

  // Iteration counter width for a given operand width.
  function automatic int div_cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  // All-ones pattern in the low w bits.
  function automatic div_word_t div_all_ones(input int w);
    return ~({DIV_MAX_W{1'b1}} << w);
  endfunction

  // Most negative two's-complement value of a w-bit word (100..0).
  function automatic div_word_t div_signed_min(input int w);
    return div_word_t'(1) << (w - 1);
  endfunction

  // Two's-complement negation; the low bits are correct for any narrower width.
  function automatic div_word_t div_neg(input div_word_t x);
    return ~x + div_word_t'(1);
  endfunction

endpackage

// File: rtl/sub_borrow.sv
// Trial subtractor: {cout,diff} = in1 + ~in2 + 1. cout=1 means no borrow.
module sub_borrow #(
  parameter int W = 33
) (
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  output logic [W-1:0] diff,
  output logic         cout
);

  logic [W:0] sum;

  assign sum          = {1'b0, in1} + {1'b0, ~in2} + {{W{1'b0}}, 1'b1};
  assign {cout, diff} = sum;

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU. One quotient bit per
// BUSY cycle, sign fix-up on the final iteration, RISC-V special cases
// (divide by zero, signed overflow) answered one cycle after accept.
module iter_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int               CNT_W      = div_cnt_w(WIDTH);
  localparam logic [WIDTH-1:0] ALL_ONES   = WIDTH'(div_all_ones(WIDTH));
  localparam logic [WIDTH-1:0] SIGNED_MIN = WIDTH'(div_signed_min(WIDTH));

  div_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;

  // Operand magnitudes and signs, used only on the accept cycle.
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic             is_div_zero;
  logic             is_overflow;
  logic             accept;

  assign dvd_neg     = is_signed & dividend[WIDTH-1];
  assign dvs_neg     = is_signed & divisor[WIDTH-1];
  assign dvd_mag     = dvd_neg ? WIDTH'(div_neg(div_word_t'(dividend))) : dividend;
  assign dvs_mag     = dvs_neg ? WIDTH'(div_neg(div_word_t'(divisor)))  : divisor;
  assign is_div_zero = (divisor == '0);
  assign is_overflow = is_signed && (dividend == SIGNED_MIN) && (divisor == ALL_ONES);
  assign accept      = in_valid && (state_reg == IDLE) && !flush;
  assign in_ready    = (state_reg == IDLE);

  // One restoring step: shift {rem,quo} left, try subtracting the divisor.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic             unused_trial_msb;

  assign rem_sh = {rem_reg, quo_reg[WIDTH-1]};

  sub_borrow #(
    .W (WIDTH + 1)
  ) u_sub_borrow (
    .in1  (rem_sh),
    .in2  ({1'b0, dvs_reg}),
    .diff (trial),
    .cout (no_borrow)
  );

  // A successful subtraction always leaves the top bit clear.
  assign unused_trial_msb = trial[WIDTH];
  assign rem_nx           = no_borrow ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_nx           = {quo_reg[WIDTH-2:0], no_borrow};

  // Final results with signs restored, written on the BUSY->DONE edge.
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign quo_fix = neg_q_reg ? WIDTH'(div_neg(div_word_t'(quo_nx))) : quo_nx;
  assign rem_fix = neg_r_reg ? WIDTH'(div_neg(div_word_t'(rem_nx))) : rem_nx;

  // Control FSM with datapath registers and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      dvs_reg     <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (is_div_zero) begin
              quotient    <= ALL_ONES;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state_reg   <= DONE;
            end else if (is_overflow) begin
              quotient    <= dividend;
              remainder   <= '0;
              div_by_zero <= 1'b0;
              out_valid   <= 1'b1;
              state_reg   <= DONE;
            end else begin
              rem_reg     <= '0;
              quo_reg     <= dvd_mag;
              dvs_reg     <= dvs_mag;
              neg_q_reg   <= dvd_neg ^ dvs_neg;
              neg_r_reg   <= dvd_neg;
              cnt_reg     <= CNT_W'(WIDTH - 1);
              div_by_zero <= 1'b0;
              state_reg   <= BUSY;
            end
          end
        end
        BUSY: begin
          if (flush) begin
            state_reg <= IDLE;
          end else begin
            rem_reg <= rem_nx;
            quo_reg <= quo_nx;
            cnt_reg <= cnt_reg - CNT_W'(1);
            if (cnt_reg == '0) begin
              quotient  <= quo_fix;
              remainder <= rem_fix;
              out_valid <= 1'b1;
              state_reg <= DONE;
            end
          end
        end
        DONE: begin
          // A flush coinciding with the transfer still discards the result.
          if (flush || out_ready) begin
            out_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: stimulus pushes expected results into a
// scoreboard queue, an independent negedge monitor checks latency and data.
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  iter_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  logic ov_prev = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: latency on the rising edge of out_valid, data on each transfer.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready && !flush) acc_cyc = cyc + 1;
    if (out_valid && !ov_prev) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_out_valid: got 1 expected 0 at cycle %0d", cyc);
      end else begin
        chk("latency", 32'(cyc - acc_cyc + 1), 32'(sb[0].lat));
      end
    end
    if (out_valid && out_ready && !flush && sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      $display("result q=0x%08h r=0x%08h dbz=%0d (exp q=0x%08h r=0x%08h dbz=%0d)",
               quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
      chk("quotient", quotient, e.q);
      chk("remainder", remainder, e.r);
      chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
    end
    ov_prev = out_valid;
  end

  // Wait for in_ready, present one operation for exactly one accepting edge.
  task automatic issue(input logic sg, input logic [31:0] a, input logic [31:0] b,
                       input logic push, input logic [31:0] eq, input logic [31:0] er,
                       input logic ed, input int lat);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
      return;
    end
    e.q = eq; e.r = er; e.dbz = ed; e.lat = lat;
    if (push) sb.push_back(e);
    $display("issue signed=%0d 0x%08h / 0x%08h", sg, a, b);
    is_signed = sg; dividend = a; divisor = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && !out_valid) return;
    end
    n_vec++;
    n_bad++;
    $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; is_signed = 1'b0;
    dividend = '0; divisor = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_quotient", quotient, 32'd0);
    chk("reset_remainder", remainder, 32'd0);
    chk("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;

    // Normal and special-case operations with out_ready held high.
    issue(1'b0, 32'd100,        32'd7,          1'b1, 32'd14,         32'd2,          1'b0, 33);
    issue(1'b1, 32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 33);
    issue(1'b1, 32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          1'b0, 33);
    issue(1'b1, 32'd5,          32'd0,          1'b1, 32'hFFFFFFFF,   32'd5,          1'b1, 1);
    issue(1'b0, 32'd5,          32'd0,          1'b1, 32'hFFFFFFFF,   32'd5,          1'b1, 1);
    issue(1'b1, 32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0, 1);
    issue(1'b0, 32'h80000000,   32'hFFFFFFFF,   1'b1, 32'd0,          32'h80000000,   1'b0, 33);
    issue(1'b0, 32'hFFFFFFFF,   32'd1,          1'b1, 32'hFFFFFFFF,   32'd0,          1'b0, 33);
    issue(1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, 32'd14,         32'hFFFFFFFE,   1'b0, 33);
    issue(1'b1, 32'hFFFFFFF8,   32'd3,          1'b1, 32'hFFFFFFFE,   32'hFFFFFFFE,   1'b0, 33);
    issue(1'b0, 32'd3,          32'd10,         1'b1, 32'd0,          32'd3,          1'b0, 33);
    issue(1'b1, 32'd0,          32'hFFFFFFFB,   1'b1, 32'd0,          32'd0,          1'b0, 33);
    drain();

    // Back-pressure: result held for 5 cycles with out_ready low.
    out_ready = 1'b0;
    issue(1'b0, 32'd1000, 32'd10, 1'b1, 32'd100, 32'd0, 1'b0, 33);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        break;
      end
    end
    chk("hold_out_valid_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_quotient", quotient, 32'd100);
      chk("hold_remainder", remainder, 32'd0);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("release_out_valid", {31'd0, out_valid}, 32'd0);
    chk("release_sb_empty", 32'(sb.size()), 32'd0);

    // Flush in BUSY cycle 10: result must never appear.
    issue(1'b0, 32'd50, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0, 0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("flush_no_result", 32'(seen), 32'd0);

    // Flush in IDLE blocks the accept in that cycle.
    @(posedge clk); #1;
    is_signed = 1'b0; dividend = 32'd8; divisor = 32'd2;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_in_ready", {31'd0, in_ready}, 32'd1);

    // Asynchronous reset mid-BUSY clears everything immediately.
    issue(1'b0, 32'd77, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0, 0);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_quotient", quotient, 32'd0);
    chk("async_rst_remainder", remainder, 32'd0);
    chk("async_rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Normal operation resumes after reset.
    issue(1'b0, 32'd9, 32'd4, 1'b1, 32'd2, 32'd1, 1'b0, 33);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
